// File: rtl/mem_err_monitor.sv
// Error monitor for the dual-memory CRC block: counts CE/UE per memory, grades the per-window
// CE rate into a sticky OK/WARN/FAULT alarm, and records the first erring memory and its cycle.
`timescale 1ns/1ps

module mem_err_monitor #(
  parameter int CNT_W        = 8,
  parameter int WIN_LEN      = 64,
  parameter int WARN_THRESH  = 4,
  parameter int FAULT_THRESH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem1_err_detected,
  input  logic             mem1_err_corrected,
  input  logic             mem2_err_detected,
  input  logic             mem2_err_corrected,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [CNT_W-1:0] mem1_ce_cnt,
  output logic [CNT_W-1:0] mem1_ue_cnt,
  output logic [CNT_W-1:0] mem2_ce_cnt,
  output logic [CNT_W-1:0] mem2_ue_cnt,
  output logic [CNT_W-1:0] win_ce_cnt,
  output logic [1:0]       state,
  output logic             alarm_warn,
  output logic             alarm_fault,
  output logic [1:0]       first_err_src,
  output logic [31:0]      first_err_cycle
);

  localparam int               WIN_W    = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WARN_TH  = CNT_W'(WARN_THRESH);
  localparam logic [CNT_W-1:0] FAULT_TH = CNT_W'(FAULT_THRESH);

  typedef enum logic [1:0] {
    ST_OK    = 2'd0,
    ST_WARN  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [1:0] det_raw, corr_raw;
  logic [1:0] det_d1_reg, det_d2_reg, corr_d1_reg;
  logic [1:0] evt, ce_evt, ue_evt;
  logic [1:0] ce_num;
  logic       fault_hit;
  logic       win_wrap;
  logic       clr_q_reg;
  logic       clr_ack_reg;

  logic [1:0][CNT_W-1:0] ce_cnt, ue_cnt;
  logic [CNT_W-1:0]      win_ce_reg, win_ce_next;
  logic [WIN_W-1:0]      win_pos_reg;
  logic [31:0]           cycle_cnt_reg;
  logic [1:0]            first_src_reg;
  logic [31:0]           first_cycle_reg;

  // Add a 0..2 event count to a counter, clamping at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W+1:0] s;
    s = {2'b00, a} + {{CNT_W{1'b0}}, b};
    return (s > {2'b00, CNT_MAX}) ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  assign det_raw  = {mem2_err_detected, mem1_err_detected};
  assign corr_raw = {mem2_err_corrected, mem1_err_corrected};

  // The input pipeline keeps sampling through a clear so a held level is not re-counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_d1_reg  <= '0;
      det_d2_reg  <= '0;
      corr_d1_reg <= '0;
    end else begin
      det_d1_reg  <= det_raw;
      det_d2_reg  <= det_d1_reg;
      corr_d1_reg <= corr_raw;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
      logic [CNT_W-1:0] ce_q, ue_q;

      assign evt[gi]    = det_d1_reg[gi] & ~det_d2_reg[gi];
      assign ce_evt[gi] = evt[gi] & corr_d1_reg[gi];
      assign ue_evt[gi] = evt[gi] & ~corr_d1_reg[gi];
      assign ce_cnt[gi] = ce_q;
      assign ue_cnt[gi] = ue_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ce_q <= '0;
          ue_q <= '0;
        end else if (clr_req) begin
          ce_q <= '0;
          ue_q <= '0;
        end else begin
          if (ce_evt[gi] && (ce_q != CNT_MAX)) ce_q <= ce_q + CNT_W'(1);
          if (ue_evt[gi] && (ue_q != CNT_MAX)) ue_q <= ue_q + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign ce_num      = {1'b0, ce_evt[0]} + {1'b0, ce_evt[1]};
  assign win_wrap    = (win_pos_reg == WIN_LAST);
  // The wrap cycle's events open the new window instead of closing the old one.
  assign win_ce_next = win_wrap ? sat_add('0, ce_num) : sat_add(win_ce_reg, ce_num);
  assign fault_hit   = (|ue_evt) || (win_ce_next >= FAULT_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg <= '0;
      win_pos_reg   <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      win_pos_reg   <= win_wrap ? '0 : win_pos_reg + WIN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_ce_reg      <= '0;
      first_src_reg   <= '0;
      first_cycle_reg <= '0;
    end else if (clr_req) begin
      win_ce_reg      <= '0;
      first_src_reg   <= '0;
      first_cycle_reg <= '0;
    end else begin
      win_ce_reg <= win_ce_next;
      // A non-zero source doubles as the "already captured" flag.
      if ((first_src_reg == 2'd0) && (|evt)) begin
        first_src_reg   <= evt;
        first_cycle_reg <= cycle_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_q_reg   <= 1'b0;
      clr_ack_reg <= 1'b0;
    end else begin
      clr_q_reg   <= clr_req;
      clr_ack_reg <= clr_req & ~clr_q_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_OK;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (clr_req) begin
      state_next = ST_OK;
    end else begin
      case (state_reg)
        ST_OK: begin
          if (fault_hit)                       state_next = ST_FAULT;
          else if (win_ce_next >= WARN_TH)     state_next = ST_WARN;
        end
        ST_WARN: begin
          if (fault_hit)                       state_next = ST_FAULT;
        end
        default:                               state_next = ST_FAULT;
      endcase
    end
  end

  assign mem1_ce_cnt     = ce_cnt[0];
  assign mem1_ue_cnt     = ue_cnt[0];
  assign mem2_ce_cnt     = ce_cnt[1];
  assign mem2_ue_cnt     = ue_cnt[1];
  assign win_ce_cnt      = win_ce_reg;
  assign state           = state_reg;
  assign alarm_warn      = (state_reg == ST_WARN);
  assign alarm_fault     = (state_reg == ST_FAULT);
  assign first_err_src   = first_src_reg;
  assign first_err_cycle = first_cycle_reg;
  assign clr_ack         = clr_ack_reg;

endmodule
